// File: rtl/rr_arb_pkg.sv
// rr_arb_pkg: shared types, default sizes and helpers for the round-robin ring arbiter.
package rr_arb_pkg;
  typedef enum logic {IDLE, GRANT} state_t;
  localparam int N_DEF = 4;
  localparam int HOLD_MAX_DEF = 8;
  function automatic logic [3:0] onehot_to_bin(input logic [15:0] oh);
    onehot_to_bin = '0;
    for (int i = 0; i < 16; i++)
      if (oh[i]) onehot_to_bin = onehot_to_bin | 4'(i);
  endfunction
endpackage

// File: rtl/rr_ring_ptr.sv
// rr_ring_ptr: combinational circular priority picker, searching upward from the one-hot ptr.
module rr_ring_ptr #(
  parameter int N = 4
) (
  input  logic [N-1:0] req,
  input  logic [N-1:0] ptr,
  output logic [N-1:0] pick,
  output logic         any_req
);
  logic [N-1:0] hi;
  // Requests at or above ptr win; otherwise wrap to the lowest set bit overall.
  assign hi      = req & ~(ptr - N'(1));
  assign pick    = |hi ? hi & (~hi + N'(1)) : req & (~req + N'(1));
  assign any_req = |req;
endmodule

// File: rtl/rr_ring_arbiter.sv
// rr_ring_arbiter: round-robin arbiter with one-hot ring pointer and held grants.
// Define HOLD_TIMEOUT_EN to revoke a grant after HOLD_MAX cycles.
module rr_ring_arbiter
  import rr_arb_pkg::*;
#(
  parameter int N        = N_DEF,
  parameter int HOLD_MAX = HOLD_MAX_DEF,
  parameter int ID_W     = $clog2(N)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [N-1:0]    req,
  output logic [N-1:0]    grant,
  output logic            grant_valid,
  output logic [ID_W-1:0] grant_id,
  output logic [N-1:0]    ptr
);
  if (N < 2 || N > 16) begin : g_bad_n
    $error("rr_ring_arbiter: N must be 2..16");
  end
  if (HOLD_MAX < 1) begin : g_bad_hold
    $error("rr_ring_arbiter: HOLD_MAX must be >= 1");
  end
  state_t          state_q, state_d;
  logic [N-1:0]    grant_q, grant_d, ptr_q, ptr_d, pick;
  logic [ID_W-1:0] id_q, id_d;
  logic            any_req, rel;
  rr_ring_ptr #(.N(N)) u_pick (
    .req    (req),
    .ptr    (ptr_q),
    .pick   (pick),
    .any_req(any_req)
  );
`ifdef HOLD_TIMEOUT_EN
  localparam int HW = $clog2(HOLD_MAX + 1);
  logic [HW-1:0] hold_q, hold_d;
  assign hold_d = (state_q == GRANT) ? hold_q + HW'(1) : '0;
  assign rel    = !req[id_q] || hold_q == HW'(HOLD_MAX - 1);
  always_ff @(posedge clk or posedge reset)
    if (reset) hold_q <= '0;
    else hold_q <= hold_d;
`else
  assign rel = !req[id_q];
`endif
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    id_d    = id_q;
    ptr_d   = ptr_q;
    if (state_q == IDLE) begin
      if (any_req) begin
        state_d = GRANT;
        grant_d = pick;
        id_d    = ID_W'(onehot_to_bin(16'(pick)));
      end
    end else if (rel) begin
      state_d = IDLE;
      grant_d = '0;
      // Releasing requester drops to lowest priority.
      ptr_d   = {grant_q[N-2:0], grant_q[N-1]};
    end
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state_q <= IDLE;
      grant_q <= '0;
      id_q    <= '0;
      ptr_q   <= N'(1);
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      id_q    <= id_d;
      ptr_q   <= ptr_d;
    end
  assign grant       = grant_q;
  assign grant_valid = |grant_q;
  assign grant_id    = id_q;
  assign ptr         = ptr_q;
endmodule

// File: doc/rr_ring_arbiter.md
Name: rr_ring_arbiter

Overview:
Round-robin arbiter that shares one counter/datapath resource between N requesters, using a one-hot ring-counter priority pointer. It sits in front of the shared binary up counter and grants exclusive use to one requester at a time. A grant is held until the requester releases it, or optionally until a hold timeout expires.

Parameters:
N, 4, number of requesters (2..16)
HOLD_MAX, 8, maximum grant length in cycles; used only when HOLD_TIMEOUT_EN is defined (>=1)
ID_W, $clog2(N), width of grant_id

Ports:
clk  input  1  rising-edge clock
reset  input  1  asynchronous, active-high reset
req  input  N  request vector; bit i held high while requester i wants or holds the resource
grant  output  N  one-hot grant, registered; all zero when idle
grant_valid  output  1  high whenever grant is non-zero
grant_id  output  ID_W  binary index of the granted requester; holds its last value when idle
ptr  output  N  one-hot ring priority pointer, for debug/visibility

Behaviour:
- Reset (async, immediate) sets:
  - grant=0, grant_valid=0, grant_id=0
  - ptr=one-hot bit0
  - state=IDLE, hold_cnt=0
- States: IDLE, GRANT.
- IDLE:
  - If req!=0 at a posedge, grant the first set req bit found by searching circularly upward from the ptr position (the ptr position itself is included).
  - Latency: req sampled at edge k gives grant registered at edge k (visible after edge k).
  - Set grant_id, grant_valid=1, hold_cnt=0, state -> GRANT.
  - If req==0, stay in IDLE with outputs at zero.
- GRANT:
  - If req[grant_id]==1, hold grant and increment hold_cnt.
  - If req[grant_id]==0 at an edge, release: grant=0, grant_valid=0, state -> IDLE.
  - On release, ptr rotates to one-hot (grant_id+1) mod N, so the releasing requester becomes lowest priority.
  - There is exactly one idle bubble cycle between consecutive grants.
- Changes on other req bits during GRANT are ignored, with no preemption.
- Wrap-around: grant_id=N-1 on release gives ptr=bit0.
- ptr only changes on release or timeout, never in IDLE.
- grant is always one-hot or zero; grant_valid == |grant.
- Reset asserted mid-GRANT clears grant combinationally-async before the next edge. After reset deassertion, arbitration restarts from bit0.

Optional Feature:
Macro HOLD_TIMEOUT_EN.
- Defined:
  - In GRANT, when hold_cnt==HOLD_MAX-1 and req[grant_id] is still 1, revoke at the next edge exactly like a release (grant=0, ptr advances, state -> IDLE).
  - The grant therefore lasts at most HOLD_MAX cycles.
  - The requester must keep or re-assert req and compete again at lowest priority.
- Undefined:
  - hold_cnt logic is removed and a grant persists indefinitely while req stays high.

Decomposition:
- Shared package rr_arb_pkg holds:
  - state enum type (IDLE, GRANT)
  - default constants N_DEF=4 and HOLD_MAX_DEF=8
  - a function onehot_to_bin
- One natural sub-module: rr_ring_ptr, the combinational circular priority picker. Inputs are req and ptr; outputs are a one-hot pick and any_req. It is instantiated once.
- State, hold counter and ptr registers stay in the top module.

Test Plan:
- Reset: hold reset=1 for 15 ns with req=4'b1111 -> grant=0000, grant_valid=0, grant_id=0, ptr=0001. Then pulse reset at 3 ns after an edge while grant=0010 -> grant=0000 immediately, before the next posedge.
- Single request:
  - req=0100 set at a negedge -> after the next posedge grant=0100, grant_id=2, grant_valid=1.
  - Drop req -> the next posedge gives grant=0000 and ptr=1000.
- Rotation: req=1111 and the bench drops the granted bit for one cycle after each 2-cycle grant -> grant order 0001, 0010, 0100, 1000, 0001, with exactly one zero cycle between each grant.
- Wrap and skip: after releasing id 3 (ptr=0001), apply req=1010 -> grant=0010. Release it, then req=1001 -> grant=1000 (ptr=0100 so search is 2,3).
- Timeout (HOLD_TIMEOUT_EN defined, HOLD_MAX=8): req=0011 held constant -> grant=0001 for exactly 8 cycles, then 0000 for 1 cycle, then 0010 for 8 cycles, then 0000, then 0001.
- No timeout (macro undefined): same stimulus -> grant=0001 is held for 20+ cycles and ptr remains 0001.
